// File: rtl/operate_sequencer.sv
// Multi-cycle sequencer for LC-3 operate instructions (ADD, AND, NOT).
// Drives a register file's index/write ports, computes the result and updates NZP.
module operate_sequencer #(
    parameter int         WIDTH    = 16,
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [15:0]      IR,
    input  logic [WIDTH-1:0] SR1_Out,
    input  logic [WIDTH-1:0] SR2_Out,
    output logic [2:0]       DR,
    output logic [2:0]       SR1,
    output logic [2:0]       SR2,
    output logic             LD_REG,
    output logic [WIDTH-1:0] In,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    state_t           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       nzp_q, nzp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             ld_reg_q, ld_reg_d;

    logic [3:0]       opcode;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] alu_out;

    assign opcode = ir_q[15:12];
    assign op2    = ir_q[5] ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : SR2_Out;

    always_comb begin
        unique case (opcode)
            OP_ADD:  alu_out = SR1_Out + op2;
            OP_AND:  alu_out = SR1_Out & op2;
            default: alu_out = ~SR1_Out;
        endcase
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        result_d  = result_q;
        nzp_d     = nzp_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        ld_reg_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    ir_d      = IR;
                    illegal_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_ADD || opcode == OP_AND || opcode == OP_NOT) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_EXECUTE: begin
                result_d = alu_out;
                ld_reg_d = 1'b1;
                state_d  = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                nzp_d[2] = result_q[WIDTH-1];
                nzp_d[1] = (result_q == '0);
                nzp_d[0] = !result_q[WIDTH-1] && (result_q != '0);
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            result_q  <= '0;
            nzp_q     <= CC_RESET;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            ld_reg_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            nzp_q     <= nzp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            ld_reg_q  <= ld_reg_d;
        end
    end

    // Masking with Reset keeps a writeback from landing on the reset edge.
    assign LD_REG  = ld_reg_q & ~Reset;
    assign DR      = ir_q[11:9];
    assign SR1     = ir_q[8:6];
    assign SR2     = ir_q[2:0];
    assign In      = result_q;
    assign N       = nzp_q[2];
    assign Z       = nzp_q[1];
    assign P       = nzp_q[0];
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Illegal = illegal_q;

endmodule
